// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared FSM state, PC-select and trap-cause encodings for the trap sequencer
package msrv32_pkg;

    typedef enum logic [1:0] {
        RESET       = 2'b00,
        OPERATING   = 2'b01,
        TRAP_TAKEN  = 2'b10,
        TRAP_RETURN = 2'b11
    } trap_state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_M_SW_IRQ         = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER_IRQ      = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT_IRQ        = 4'd11;

endpackage

// File: rtl/msrv32_trap_priority.sv
// msrv32_trap_priority: combinational trap detect and mcause priority encoder
module msrv32_trap_priority
    import msrv32_pkg::*;
(
    input  logic       operating,
    input  logic       misaligned_instr,
    input  logic       illegal_instr,
    input  logic       ebreak,
    input  logic       ecall,
    input  logic       misaligned_store,
    input  logic       misaligned_load,
    input  logic       mie,
    input  logic       meie,
    input  logic       msie,
    input  logic       mtie,
    input  logic       e_irq,
    input  logic       s_irq,
    input  logic       t_irq,
    output logic       trap_detected,
    output logic       i_or_e,
    output logic [3:0] cause
);
    logic exception, e_int, s_int, t_int;

    always_comb begin
        e_int         = mie & e_irq & meie;
        s_int         = mie & s_irq & msie;
        t_int         = mie & t_irq & mtie;
        exception     = misaligned_instr | illegal_instr | ebreak | ecall | misaligned_store | misaligned_load;
        trap_detected = operating & (exception | e_int | s_int | t_int);
        // any exception outranks every interrupt
        i_or_e        = ~exception;
        cause         = misaligned_instr ? CAUSE_INSTR_MISALIGNED :
                        illegal_instr    ? CAUSE_ILLEGAL_INSTR    :
                        ebreak           ? CAUSE_BREAKPOINT       :
                        ecall            ? CAUSE_ECALL_M          :
                        misaligned_store ? CAUSE_STORE_MISALIGNED :
                        misaligned_load  ? CAUSE_LOAD_MISALIGNED  :
                        e_int            ? CAUSE_M_EXT_IRQ        :
                        s_int            ? CAUSE_M_SW_IRQ         :
                                           CAUSE_M_TIMER_IRQ;
    end
endmodule

// File: rtl/msrv32_trap_sequencer.sv
// msrv32_trap_sequencer: machine-mode trap/MRET control FSM driving PC select, flush and CSR strobes
module msrv32_trap_sequencer
    import msrv32_pkg::*;
(
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs2_addr_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       msie_in,
    input  logic       mtie_in,
    input  logic       e_irq_in,
    input  logic       s_irq_in,
    input  logic       t_irq_in,
    output logic       trap_taken_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       instret_inc_out
);
    trap_state_t state, next_state;
    logic sys_priv, ecall, ebreak, mret, trap, trap_i_or_e;
    logic [3:0] trap_cause;

    always_comb begin
        sys_priv = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == 3'b000);
        ecall    = sys_priv && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
        ebreak   = sys_priv && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
        mret     = sys_priv && (funct7_in == FUNCT7_MRET) && (rs2_addr_in == 5'd2);
    end

    msrv32_trap_priority u_priority (
        .operating        (state == OPERATING),
        .misaligned_instr (misaligned_instr_in),
        .illegal_instr    (illegal_instr_in),
        .ebreak           (ebreak),
        .ecall            (ecall),
        .misaligned_store (misaligned_store_in),
        .misaligned_load  (misaligned_load_in),
        .mie              (mie_in),
        .meie             (meie_in),
        .msie             (msie_in),
        .mtie             (mtie_in),
        .e_irq            (e_irq_in),
        .s_irq            (s_irq_in),
        .t_irq            (t_irq_in),
        .trap_detected    (trap),
        .i_or_e           (trap_i_or_e),
        .cause            (trap_cause)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state      <= RESET;
            cause_out  <= 4'd0;
            i_or_e_out <= 1'b0;
        end else begin
            state <= next_state;
            if (trap) begin
                cause_out  <= trap_cause;
                i_or_e_out <= trap_i_or_e;
            end
        end
    end

    // a trap in the same cycle as MRET wins, so MRET is only looked at when no trap is pending
    always_comb begin
        next_state      = (state == OPERATING) ? (trap ? TRAP_TAKEN : mret ? TRAP_RETURN : OPERATING) : OPERATING;
        trap_taken_out  = trap;
        pc_src_out      = (state == RESET)      ? PC_BOOT :
                          (state == OPERATING)  ? PC_NEXT :
                          (state == TRAP_TAKEN) ? PC_TRAP : PC_EPC;
        flush_out       = state != OPERATING;
        set_cause_out   = state == TRAP_TAKEN;
        set_epc_out     = state == TRAP_TAKEN;
        mie_clear_out   = state == TRAP_TAKEN;
        mie_set_out     = state == TRAP_RETURN;
        instret_inc_out = (state == OPERATING) && !trap;
    end
endmodule

// File: tb/tb_msrv32_trap_sequencer.sv
// tb_msrv32_trap_sequencer: directed self-checking bench for the trap sequencer
module tb_msrv32_trap_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic illegal, mis_instr, mis_load, mis_store;
    logic mie, meie, msie, mtie, e_irq, s_irq, t_irq;
    logic trap_taken, flush, set_cause, set_epc, mie_clear, mie_set, i_or_e, instret_inc;
    logic [1:0] pc_src;
    logic [3:0] cause;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    msrv32_trap_sequencer dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .opcode_6_to_2_in     (opcode),
        .funct3_in            (funct3),
        .funct7_in            (funct7),
        .rs2_addr_in          (rs2),
        .illegal_instr_in     (illegal),
        .misaligned_instr_in  (mis_instr),
        .misaligned_load_in   (mis_load),
        .misaligned_store_in  (mis_store),
        .mie_in               (mie),
        .meie_in              (meie),
        .msie_in              (msie),
        .mtie_in              (mtie),
        .e_irq_in             (e_irq),
        .s_irq_in             (s_irq),
        .t_irq_in             (t_irq),
        .trap_taken_out       (trap_taken),
        .pc_src_out           (pc_src),
        .flush_out            (flush),
        .set_cause_out        (set_cause),
        .set_epc_out          (set_epc),
        .mie_clear_out        (mie_clear),
        .mie_set_out          (mie_set),
        .i_or_e_out           (i_or_e),
        .cause_out            (cause),
        .instret_inc_out      (instret_inc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        opcode = 5'd0; funct3 = 3'd0; funct7 = 7'd0; rs2 = 5'd0;
        illegal = 0; mis_instr = 0; mis_load = 0; mis_store = 0;
        mie = 0; meie = 0; msie = 0; mtie = 0; e_irq = 0; s_irq = 0; t_irq = 0;
    endtask

    task automatic set_instr(input logic [6:0] f7, input logic [4:0] r2);
        opcode = 5'b11100; funct3 = 3'd0; funct7 = f7; rs2 = r2;
    endtask

    // caller has applied trap stimulus in OPERATING at posedge+1
    task automatic take_trap(input string tag, input logic [3:0] exp_cause, input logic exp_ioe);
        #1;
        check({tag, "_trap_taken"}, trap_taken, 1);
        check({tag, "_instret"}, instret_inc, 0);
        @(posedge clk); #1;
        check({tag, "_cause"}, cause, exp_cause);
        check({tag, "_i_or_e"}, i_or_e, exp_ioe);
        check({tag, "_strobes"}, {set_cause, set_epc, mie_clear, mie_set}, 4'b1110);
        check({tag, "_pc_src"}, pc_src, 2'b10);
        check({tag, "_flush"}, flush, 1);
        clear_inputs();
        #1;
        check({tag, "_tt_in_trap"}, trap_taken, 0);
        @(posedge clk); #1;
        check({tag, "_back_op"}, pc_src, 2'b11);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc_src", pc_src, 2'b00);
        check("rst_flush", flush, 1);
        check("rst_cause", {i_or_e, cause}, 5'd0);
        check("rst_strobes", {trap_taken, set_cause, set_epc, mie_clear, mie_set, instret_inc}, 6'd0);
        rst = 0;
        illegal = 1;
        #1;
        check("reset_no_trap", trap_taken, 0);
        check("boot_pc_src", pc_src, 2'b00);
        check("boot_flush", flush, 1);
        illegal = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("op_pc_src", pc_src, 2'b11);
            check("op_instret", instret_inc, 1);
            check("op_flush", flush, 0);
            @(posedge clk); #1;
        end

        illegal = 1; mis_load = 1;
        take_trap("illegal_load", 4'd2, 0);

        mie = 1; t_irq = 1; mtie = 1; e_irq = 1; meie = 1;
        take_trap("ext_timer", 4'd11, 1);

        t_irq = 1; mtie = 1; e_irq = 1; meie = 1;
        #1;
        check("mie_off_trap", trap_taken, 0);
        check("mie_off_instret", instret_inc, 1);
        @(posedge clk); #1;
        check("mie_off_pc", pc_src, 2'b11);
        check("cause_hold", cause, 4'd11);

        e_irq = 0; mie = 1; s_irq = 1; msie = 1;
        #1;
        check("sw_trap", trap_taken, 1);
        @(posedge clk); #1;
        check("sw_cause", {i_or_e, cause}, {1'b1, 4'd3});
        check("sw_held_in_trap", trap_taken, 0);
        @(posedge clk); #1;
        check("sw_retrap_pc", pc_src, 2'b11);
        check("sw_retrap", trap_taken, 1);
        clear_inputs();
        #1;
        check("sw_cleared", trap_taken, 0);
        @(posedge clk); #1;

        mie = 1; t_irq = 1; mtie = 1;
        take_trap("timer", 4'd7, 1);
        set_instr(7'd0, 5'd0);
        take_trap("ecall", 4'd11, 0);
        set_instr(7'd0, 5'd1); e_irq = 1; meie = 1; mie = 1;
        take_trap("ebreak_irq", 4'd3, 0);
        set_instr(7'd0, 5'd1); mis_instr = 1;
        take_trap("mis_instr", 4'd0, 0);
        mis_store = 1; mis_load = 1;
        take_trap("store_load", 4'd6, 0);
        mis_load = 1;
        take_trap("load", 4'd4, 0);

        set_instr(7'b0011000, 5'd2);
        #1;
        check("mret_no_trap", trap_taken, 0);
        check("mret_instret", instret_inc, 1);
        @(posedge clk); #1;
        clear_inputs();
        check("mret_pc_src", pc_src, 2'b01);
        check("mret_strobes", {mie_set, flush, set_cause, instret_inc}, 4'b1100);
        @(posedge clk); #1;
        check("mret_back", pc_src, 2'b11);

        set_instr(7'b0011000, 5'd2); illegal = 1;
        take_trap("mret_illegal", 4'd2, 0);

        illegal = 1;
        @(posedge clk); #1;
        check("pre_rst_trap_pc", pc_src, 2'b10);
        rst = 1;
        @(posedge clk); #1;
        check("midtrap_rst_pc", pc_src, 2'b00);
        check("midtrap_rst_flush", flush, 1);
        check("midtrap_rst_cause", {i_or_e, cause}, 5'd0);
        check("midtrap_rst_strobes", {trap_taken, set_cause, set_epc, mie_clear, mie_set}, 5'd0);
        clear_inputs();
        rst = 0;
        @(posedge clk); #1;
        check("after_rst_pc", pc_src, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
